// File: rtl/multi_pueo_beamform_v3.sv
// -----------------------------------------------------------------------------
// multi_pueo_beamform_v3
//
// Multi-beam coherent-sum beamformer with per-beam power windows.
//
// Each offset-binary input code is mapped to an odd symmetric value
// v = 2x - (2^NBITS-1). For every beam and sample, the enabled channels are
// summed through a fully pipelined pairwise adder tree, one register per
// level, and the sum is squared exactly. The squares of each beam are then
// summed over samples and accumulated over WINLEN valid cycles into a
// saturating power accumulator. The result is reported with a one-cycle strobe.
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      beam_i / chmask_i valid this cycle
//   beam_i       samples; beam b, chan c, sample s at ((b*NCHAN+c)*NSAMP+s)*NBITS
//   chmask_i     per-channel include mask, shared by all beams
//   clear_i      abort the power window in progress
//   sq_o         unsigned squares; beam b, sample s at (b*NSAMP+s)*SQBITS
//   sq_valid_o   sq_o valid
//   pow_o        per-beam window power; beam b at b*PBITS
//   pow_valid_o  one-cycle strobe, pow_o/sat_o valid
//   sat_o        per-beam saturation flag for the reported window
// -----------------------------------------------------------------------------
module multi_pueo_beamform_v3 #(
  parameter int NBEAMS = 2,
  parameter int NCHAN  = 8,
  parameter int NSAMP  = 8,
  parameter int NBITS  = 5,
  parameter int WINLEN = 4,
  parameter int PBITS  = 24,
  localparam int CB     = $clog2(NCHAN),
  localparam int SBITS  = NBITS + 1 + CB,
  localparam int SQBITS = 2 * (NBITS + CB)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  input  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0] beam_i,
  input  logic [NCHAN-1:0]                  chmask_i,
  input  logic                              clear_i,
  output logic [NBEAMS*NSAMP*SQBITS-1:0]    sq_o,
  output logic                              sq_valid_o,
  output logic [NBEAMS*PBITS-1:0]           pow_o,
  output logic                              pow_valid_o,
  output logic [NBEAMS-1:0]                 sat_o
);

  // Tree is padded to a power of two; padded leaves are constant zero.
  localparam int NP   = 1 << CB;
  localparam int NL   = NBEAMS * NSAMP;
  localparam int SUMW = SQBITS + $clog2(NSAMP) + 1;
  localparam int WW   = ((PBITS > SUMW) ? PBITS : SUMW) + 1;
  localparam int CW   = $clog2(WINLEN + 1);

  localparam logic signed [SBITS-1:0] ODD    = SBITS'((1 << NBITS) - 1);
  localparam logic [PBITS-1:0]        PMAX_P = '1;
  localparam logic [WW-1:0]           PMAX_W = WW'(PMAX_P);

  // Offset-binary code to odd symmetric value: 2x - (2^NBITS-1).
  function automatic logic signed [SBITS-1:0] to_sym(input logic [NBITS-1:0] code);
    return $signed({{CB{1'b0}}, code, 1'b0}) - ODD;
  endfunction

  // Exact square via magnitude; |S| < 2^(NBITS+CB) so SQBITS holds it.
  function automatic logic [SQBITS-1:0] square(input logic signed [SBITS-1:0] s);
    logic [SBITS-1:0] m;
    m = s[SBITS-1] ? $unsigned(-s) : $unsigned(s);
    return SQBITS'(m) * SQBITS'(m);
  endfunction

  // Saturating add; MSB of the result flags that the clamp was applied.
  function automatic logic [PBITS:0] sat_add(input logic [PBITS-1:0] a,
                                             input logic [WW-1:0]    x);
    logic [WW-1:0] t;
    t = WW'(a) + x;
    if (t > PMAX_W) begin
      return {1'b1, PMAX_P};
    end else begin
      return {1'b0, PBITS'(t)};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Input register: data, mask and valid travel together.
  // ---------------------------------------------------------------------------
  logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0] beam_q;
  logic [NCHAN-1:0]                    mask_q;
  // vld_q[0] aligns with the input register, vld_q[k] with tree level k.
  logic [CB:0]                         vld_q;

  // Input capture and valid delay line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beam_q <= '0;
      mask_q <= '0;
      vld_q  <= '0;
    end else begin
      beam_q <= beam_i;
      mask_q <= chmask_i;
      vld_q  <= {vld_q[CB-1:0], valid_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Leaves: symmetric values, masked channels forced to exactly zero.
  // ---------------------------------------------------------------------------
  logic signed [SBITS-1:0] leaf_s [NL][NP];

  // Leaf conversion and masking.
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < NP; p++) begin
        leaf_s[l][p] = '0;
      end
    end
    for (int b = 0; b < NBEAMS; b++) begin
      for (int s = 0; s < NSAMP; s++) begin
        for (int c = 0; c < NCHAN; c++) begin
          if (mask_q[c]) begin
            leaf_s[b*NSAMP+s][c] = to_sym(beam_q[((b*NCHAN+c)*NSAMP+s)*NBITS +: NBITS]);
          end else begin
            leaf_s[b*NSAMP+s][c] = '0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree stored heap-style per lane: node i has children 2i and 2i+1,
  // indices >= NP denote leaves. Node 1 is the root, CB levels deep.
  // ---------------------------------------------------------------------------
  logic signed [SBITS-1:0] node_q [NL][1:NP-1];

  for (genvar gl = 0; gl < NL; gl++) begin : g_lane
    for (genvar gi = 1; gi < NP; gi++) begin : g_node
      if (2*gi >= NP) begin : g_leafpair
        // Bottom tree level: sum of two leaves.
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            node_q[gl][gi] <= '0;
          end else begin
            node_q[gl][gi] <= leaf_s[gl][2*gi-NP] + leaf_s[gl][2*gi+1-NP];
          end
        end
      end else begin : g_inner
        // Upper tree level: sum of two registered child nodes.
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            node_q[gl][gi] <= '0;
          end else begin
            node_q[gl][gi] <= node_q[gl][2*gi] + node_q[gl][2*gi+1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Square stage
  // ---------------------------------------------------------------------------
  logic [NBEAMS*NSAMP*SQBITS-1:0] sq_d;
  logic [NBEAMS*NSAMP*SQBITS-1:0] sq_q;
  logic                           sq_valid_q;

  // Square of each lane's root sum.
  always_comb begin
    sq_d = '0;
    for (int l = 0; l < NL; l++) begin
      sq_d[l*SQBITS +: SQBITS] = square(node_q[l][1]);
    end
  end

  // Square register and its valid bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q       <= '0;
      sq_valid_q <= 1'b0;
    end else begin
      sq_q       <= sq_d;
      sq_valid_q <= vld_q[CB];
    end
  end

  // ---------------------------------------------------------------------------
  // Power window
  // ---------------------------------------------------------------------------
  logic [WW-1:0]           bsum_s [NBEAMS];
  logic [CW-1:0]           cnt_q, cnt_d, win_cnt_s;
  logic                    win_end_s;
  logic [NBEAMS*PBITS-1:0] acc_q, acc_d, base_acc_s, new_acc_s;
  logic [NBEAMS-1:0]       accsat_q, accsat_d, new_sat_s;
  logic [NBEAMS*PBITS-1:0] pow_q, pow_d;
  logic [NBEAMS-1:0]       sat_q, sat_d;
  logic                    pow_valid_q, pow_valid_d;
  logic [PBITS:0]          add_s [NBEAMS];

  // Per-beam sum of the squares across samples.
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      bsum_s[b] = '0;
      for (int s = 0; s < NSAMP; s++) begin
        bsum_s[b] = bsum_s[b] + WW'(sq_q[(b*NSAMP+s)*SQBITS +: SQBITS]);
      end
    end
  end

  // Window next-state. clear_i zeroes the base first, so a coincident
  // valid square becomes entry 0 of the fresh window.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    accsat_d    = accsat_q;
    pow_d       = pow_q;
    sat_d       = sat_q;
    pow_valid_d = 1'b0;
    win_cnt_s   = clear_i ? '0 : cnt_q;
    base_acc_s  = clear_i ? '0 : acc_q;
    win_end_s   = (win_cnt_s == CW'(WINLEN - 1));
    new_acc_s   = '0;
    new_sat_s   = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      add_s[b] = sat_add(base_acc_s[b*PBITS +: PBITS], bsum_s[b]);
      new_acc_s[b*PBITS +: PBITS] = add_s[b][PBITS-1:0];
      new_sat_s[b] = add_s[b][PBITS] | (accsat_q[b] & ~clear_i);
    end
    if (sq_valid_q) begin
      if (win_end_s) begin
        pow_d       = new_acc_s;
        sat_d       = new_sat_s;
        pow_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
        accsat_d    = '0;
      end else begin
        cnt_d    = win_cnt_s + CW'(1);
        acc_d    = new_acc_s;
        accsat_d = new_sat_s;
      end
    end else if (clear_i) begin
      cnt_d    = '0;
      acc_d    = '0;
      accsat_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Window state and reported outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      accsat_q    <= '0;
      pow_q       <= '0;
      sat_q       <= '0;
      pow_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      accsat_q    <= accsat_d;
      pow_q       <= pow_d;
      sat_q       <= sat_d;
      pow_valid_q <= pow_valid_d;
    end
  end

  assign sq_o        = sq_q;
  assign sq_valid_o  = sq_valid_q;
  assign pow_o       = pow_q;
  assign pow_valid_o = pow_valid_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_multi_pueo_beamform_v3.sv
// Scoreboard bench: two instances (PBITS 24 and 20) share one input stream.
module tb_multi_pueo_beamform_v3;
  localparam int NB  = 2;
  localparam int NC  = 8;
  localparam int NS  = 8;
  localparam int NBT = 5;
  localparam int WL  = 4;
  localparam int LAT = 5;
  localparam int BW  = NB*NC*NS*NBT;
  localparam int SQW = 16;
  localparam int SW  = NB*NS*SQW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, valid, clear;
  logic [BW-1:0] beam;
  logic [NC-1:0] mask;
  logic [SW-1:0] sq_a, sq_b;
  logic          sqv_a, sqv_b, pv_a, pv_b;
  logic [47:0]   pow_a;
  logic [39:0]   pow_b;
  logic [1:0]    sat_a, sat_b;

  multi_pueo_beamform_v3 #(.PBITS(24)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .beam_i(beam), .chmask_i(mask),
    .clear_i(clear), .sq_o(sq_a), .sq_valid_o(sqv_a), .pow_o(pow_a),
    .pow_valid_o(pv_a), .sat_o(sat_a));

  multi_pueo_beamform_v3 #(.PBITS(20)) u_dut20 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .beam_i(beam), .chmask_i(mask),
    .clear_i(clear), .sq_o(sq_b), .sq_valid_o(sqv_b), .pow_o(pow_b),
    .pow_valid_o(pv_b), .sat_o(sat_b));

  typedef struct { int cyc; logic [SW-1:0] sq; } sq_exp_t;
  typedef struct { int cyc; longint bs0; longint bs1; } arr_t;
  typedef struct { int cyc; logic [47:0] pa; logic [39:0] pb; logic [1:0] sa; logic [1:0] sb; } pow_exp_t;

  sq_exp_t  sqq [$];
  arr_t     pendq [$];
  pow_exp_t powq [$];

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     wcnt;
  longint acc_m [2][2];
  bit     sat_m [2][2];
  longint pmax [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    wcnt = 0;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) begin
        acc_m[k][b] = 0;
        sat_m[k][b] = 1'b0;
      end
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_sq"},   256'(sq_a),  256'd0);
    chk({nm, "_sqv"},  256'({sqv_a, sqv_b}), 256'd0);
    chk({nm, "_pow"},  256'({pow_a, pow_b}), 256'd0);
    chk({nm, "_powv"}, 256'({pv_a, pv_b}), 256'd0);
    chk({nm, "_sat"},  256'({sat_a, sat_b}), 256'd0);
  endtask

  // pat: 0 random codes, 1 all 31, 2 all 0, 3 alternating 31/0, 4 ch0=16 rest 31
  // mmode: 0 all channels, 1 random mask, 2 channel 0 only
  task automatic step(input bit v, input int pat, input int mmode, input bit clr);
    logic [BW-1:0] bm;
    logic [NC-1:0] mk;
    logic [SW-1:0] sqx;
    longint bs [2];
    int code, sum;
    arr_t a;
    pow_exp_t pe;
    bit sqv;
    @(posedge clk);
    #1;
    mk = (mmode == 0) ? 8'hFF : (mmode == 2) ? 8'h01 : 8'($urandom);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) begin
          case (pat)
            1: code = 31;
            2: code = 0;
            3: code = (c % 2 == 0) ? 31 : 0;
            4: code = (c == 0) ? 16 : 31;
            default: code = int'($urandom_range(0, 31));
          endcase
          bm[((b*NC+c)*NS+s)*NBT +: NBT] = 5'(code);
        end
    valid = v; beam = bm; mask = mk; clear = clr;
    if (v) begin
      sqx = '0;
      for (int b = 0; b < NB; b++) begin
        bs[b] = 0;
        for (int s = 0; s < NS; s++) begin
          sum = 0;
          for (int c = 0; c < NC; c++)
            if (mk[c]) sum += 2*int'(bm[((b*NC+c)*NS+s)*NBT +: NBT]) - 31;
          sqx[(b*NS+s)*SQW +: SQW] = 16'(sum*sum);
          bs[b] += longint'(sum*sum);
        end
      end
      sqq.push_back('{cyc + LAT, sqx});
      pendq.push_back('{cyc + LAT, bs[0], bs[1]});
    end
    // Window model for the square result that appears this cycle.
    sqv = 1'b0;
    if (pendq.size() > 0 && pendq[0].cyc == cyc) begin
      a = pendq.pop_front();
      sqv = 1'b1;
    end
    if (clr) model_reset();
    if (sqv) begin
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 2; b++) begin
          acc_m[k][b] += (b == 0) ? a.bs0 : a.bs1;
          if (acc_m[k][b] > pmax[k]) begin
            acc_m[k][b] = pmax[k];
            sat_m[k][b] = 1'b1;
          end
        end
      wcnt++;
      if (wcnt == WL) begin
        pe.cyc = cyc + 1;
        pe.pa = {24'(acc_m[0][1]), 24'(acc_m[0][0])};
        pe.pb = {20'(acc_m[1][1]), 20'(acc_m[1][0])};
        pe.sa = {sat_m[0][1], sat_m[0][0]};
        pe.sb = {sat_m[1][1], sat_m[1][0]};
        powq.push_back(pe);
        model_reset();
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  sq_exp_t  me;
  pow_exp_t mp;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sqv_a || sqv_b) begin
        if (sqq.size() == 0) begin
          total++; bad++;
          $display("FAIL sq_unexpected cyc=%0d got=%b%b want=00", cyc, sqv_a, sqv_b);
        end else begin
          me = sqq.pop_front();
          chk("sq_cycle", 256'(cyc), 256'(me.cyc));
          chk("sq_valid_pair", 256'({sqv_a, sqv_b}), 256'(2'b11));
          chk("sq_data", 256'(sq_a), 256'(me.sq));
          chk("sq_data_p20", 256'(sq_b), 256'(me.sq));
        end
      end else if (sqq.size() > 0 && sqq[0].cyc <= cyc) begin
        me = sqq.pop_front();
        total++; bad++;
        $display("FAIL sq_missing cyc=%0d got=0 want=1 at %0d", cyc, me.cyc);
      end
      if (pv_a || pv_b) begin
        if (powq.size() == 0) begin
          total++; bad++;
          $display("FAIL pow_unexpected cyc=%0d got=%b%b want=00", cyc, pv_a, pv_b);
        end else begin
          mp = powq.pop_front();
          chk("pow_cycle", 256'(cyc), 256'(mp.cyc));
          chk("pow_valid_pair", 256'({pv_a, pv_b}), 256'(2'b11));
          chk("pow_p24", 256'(pow_a), 256'(mp.pa));
          chk("sat_p24", 256'(sat_a), 256'(mp.sa));
          chk("pow_p20", 256'(pow_b), 256'(mp.pb));
          chk("sat_p20", 256'(sat_b), 256'(mp.sb));
        end
      end else if (powq.size() > 0 && powq[0].cyc <= cyc) begin
        mp = powq.pop_front();
        total++; bad++;
        $display("FAIL pow_missing cyc=%0d got=0 want=1 at %0d", cyc, mp.cyc);
      end
    end
  end

  initial begin
    pmax[0] = (longint'(1) << 24) - 1;
    pmax[1] = (longint'(1) << 20) - 1;
    model_reset();
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; beam = '0; mask = '0;
    #12;
    check_zero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single all-31, all-0, alternating, mask 0x01 then full mask.
    step(1, 1, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(1, 4, 2, 0);
    step(1, 4, 0, 0);
    repeat (7) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    // Full window of all-31 (saturates the PBITS=20 instance).
    repeat (4) step(1, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Same window with a 3-cycle gap after cycle 2.
    repeat (2) step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Clear after 2 valid results, then a full window.
    repeat (2) step(1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    // Clear coincident with a valid result: that result starts the new window.
    repeat (3) step(1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(1, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);

    // Randomized traffic.
    repeat (300) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);

    // Asynchronous reset mid-pipeline / mid-window.
    repeat (3) step(1, 1, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    sqq.delete(); pendq.delete(); powq.delete();
    model_reset();
    valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (200) step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    repeat (12) step(0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (sqq.size() != 0 || powq.size() != 0) begin
      bad++;
      $display("FAIL drain got sq=%0d pow=%0d pending want=0", sqq.size(), powq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_pueo_beamform_v3.md
MULTI_PUEO_BEAMFORM_V3 -- requirements
Module: multi_pueo_beamform_v3

Interface
REQ-001 Parameter NBEAMS, default 2, number of independent beams.
REQ-002 Parameter NCHAN, default 8, channels per beam; legal range 2..16.
REQ-003 Parameter NSAMP, default 8, samples per clock per channel.
REQ-004 Parameter NBITS, default 5, offset-binary input sample width.
REQ-005 Parameter WINLEN, default 4, valid clocks per power window; legal range 1..256.
REQ-006 Parameter PBITS, default 24, power accumulator width.
REQ-007 Derived: CB=clog2(NCHAN); SBITS=NBITS+1+CB signed sum width; SQBITS=2*(NBITS+CB) square width.
REQ-008 clk_i  in  1  sole clock; all logic on its rising edge.
REQ-009 rst_ni  in  1  asynchronous, active-low reset.
REQ-010 valid_i  in  1  beam_i and chmask_i valid this cycle.
REQ-011 beam_i  in  NBEAMS*NCHAN*NSAMP*NBITS  samples; beam b, channel c, sample s at bit offset ((b*NCHAN+c)*NSAMP+s)*NBITS.
REQ-012 chmask_i  in  NCHAN  per-channel enable, common to all beams; 1 = include.
REQ-013 clear_i  in  1  synchronous abort of the power window in progress.
REQ-014 sq_o  out  NBEAMS*NSAMP*SQBITS  unsigned squares; beam b, sample s at offset (b*NSAMP+s)*SQBITS.
REQ-015 sq_valid_o  out  1  sq_o valid.
REQ-016 pow_o  out  NBEAMS*PBITS  per-beam window power; beam b at offset b*PBITS.
REQ-017 pow_valid_o  out  1  single-cycle strobe, pow_o valid.
REQ-018 sat_o  out  NBEAMS  per-beam saturation flag for the window reported on pow_o.

Function
REQ-019 Each input code x SHALL map to the odd signed value v=2x-(2^NBITS-1), range ±(2^NBITS-1), so that the symmetric representation carries no fractional offset.
REQ-020 Per beam and sample, S = sum over channels with chmask bit set of v, a SBITS-bit signed value; masked channels SHALL contribute exactly 0.
REQ-021 sq_o SHALL equal S*S, exact with no truncation.
REQ-022 beam_i, chmask_i and valid_i SHALL be registered together on input; the mask travels aligned with its data.
REQ-023 The adder tree SHALL be pipelined with one register per pairwise level (CB levels), followed by one square register.
REQ-024 Latency from valid_i to sq_valid_o SHALL be exactly 2+CB cycles (5 at NCHAN=8); the valid bit is delayed alongside the data.
REQ-025 There is no backpressure; a new input is accepted every cycle. Data from cycles with valid_i=0 propagates, but its valid bit stays 0.
REQ-026 Power stage: per beam, P = sum over NSAMP of sq_o for each sq_valid_o cycle, accumulated over WINLEN valid cycles.
REQ-027 Window counter SHALL count sq_valid_o cycles 0..WINLEN-1 and hold during invalid gaps.
REQ-028 On the WINLEN-th valid cycle, pow_o and sat_o SHALL update one cycle later, with pow_valid_o high for exactly that one cycle; the accumulator and counter SHALL restart with no dead cycle.
REQ-029 The accumulator SHALL saturate at 2^PBITS-1; sat_o[b] SHALL be 1 if beam b saturated at any point in the reported window.
REQ-030 clear_i=1 SHALL discard the partial window: counter and accumulators reset, and no pow_valid_o pulse occurs for that window.
REQ-031 If clear_i and sq_valid_o are high in the same cycle, that sq data SHALL count as the first entry of the new window.
REQ-032 clear_i SHALL NOT affect the square pipeline; pow_o and sat_o SHALL hold their last reported values until the next strobe.

Reset
REQ-033 While rst_ni=0, all pipeline registers, valid bits, window counter and accumulators SHALL be 0, and sq_o, sq_valid_o, pow_o, pow_valid_o and sat_o SHALL be 0.
REQ-034 Reset assertion SHALL take effect immediately, without a clock; release SHALL be synchronous to clk_i; in-flight data and partial windows are lost.
REQ-035 The first valid_i after release SHALL produce sq_valid_o 2+CB cycles later and count as window entry 0.

Verification (defaults unless stated)
REQ-036 All channels enabled, all codes 31, one valid cycle -> after 5 cycles every sq_o lane = 61504 (S=248) and sq_valid_o=1 for one cycle.
REQ-037 All codes 0 -> every sq_o lane = 61504 (S=-248); channels alternating codes 31/0 -> every sq_o lane = 0.
REQ-038 chmask_i=8'h01, channel 0 code 16, other channels code 31 -> every sq_o lane = 1; mask changed on the next valid cycle takes effect exactly one result later.
REQ-039 Four consecutive valid cycles of all codes 31 -> one pow_valid_o pulse with pow_o = 1968128 per beam and sat_o=0; with a 3-cycle gap inserted after cycle 2 -> same value, pulse delayed 3 cycles.
REQ-040 PBITS=20, same stimulus as REQ-039 -> pow_o = 1048575 and sat_o=all ones; clear_i after 2 valid cycles -> no pulse, and the next full window reports 1968128 (at PBITS=24).
REQ-041 rst_ni pulsed low asynchronously mid-window and mid-pipeline -> all outputs 0 immediately, no stale sq_valid_o or pow_valid_o after release.
